// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, word-slice
// constants and the byte-enable to bit-mask expansion.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int WORD_LSB   = 2;
    localparam int BYTE_OFS_W = 2;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Bounded-hold arbitration FSM: tracks the current owner and how many
// consecutive grants it has had, and produces the combinational grants.
module dmem_arb_fsm
    import dmem_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic p0_req,
    input  logic p1_req,
    output logic p0_gnt,
    output logic p1_gnt
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              gnt0_s;
    logic              gnt1_s;
    logic              hold_ok_s;

    assign hold_ok_s = (hold_cnt_r < HOLD_MAX);

    // Grant decision and next-state computation.
    always_comb begin
        gnt0_s         = 1'b0;
        gnt1_s         = 1'b0;
        state_nxt_s    = ST_IDLE;
        hold_cnt_nxt_s = {HOLD_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                gnt0_s = p0_req;
                gnt1_s = p1_req & ~p0_req;
            end
            ST_OWN0: begin
                if (p0_req && p1_req) begin
                    gnt0_s = hold_ok_s;
                    gnt1_s = ~hold_ok_s;
                end else begin
                    gnt0_s = p0_req;
                    gnt1_s = p1_req;
                end
            end
            ST_OWN1: begin
                if (p0_req && p1_req) begin
                    gnt1_s = hold_ok_s;
                    gnt0_s = ~hold_ok_s;
                end else begin
                    gnt0_s = p0_req;
                    gnt1_s = p1_req;
                end
            end
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase

        // A repeat grant to the owner extends its run; any other grant restarts it.
        if (gnt0_s) begin
            state_nxt_s = ST_OWN0;
            if (state_r == ST_OWN0) begin
                hold_cnt_nxt_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + HOLD_ONE;
            end else begin
                hold_cnt_nxt_s = HOLD_ONE;
            end
        end else if (gnt1_s) begin
            state_nxt_s = ST_OWN1;
            if (state_r == ST_OWN1) begin
                hold_cnt_nxt_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + HOLD_ONE;
            end else begin
                hold_cnt_nxt_s = HOLD_ONE;
            end
        end else begin
            state_nxt_s    = ST_IDLE;
            hold_cnt_nxt_s = {HOLD_W{1'b0}};
        end
    end

    // State and hold-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end

    assign p0_gnt = gnt0_s;
    assign p1_gnt = gnt1_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: grants one port per
// cycle, merges byte-enabled writes and returns a registered response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 32,
    parameter int MEM_WORDS  = 64,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [3:0]            p0_be,
    input  logic [ADR_WIDTH-1:0]  p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [3:0]            p1_be,
    input  logic [ADR_WIDTH-1:0]  p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic [ADR_WIDTH-1:0]  mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int IDX_W = ADR_WIDTH - WORD_LSB;
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(MEM_WORDS);

    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  sel_we_s;
    logic [3:0]            sel_be_s;
    logic [ADR_WIDTH-1:0]  sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic [DATA_WIDTH-1:0] mask_s;
    logic                  err_s;
    logic                  acc0_s;
    logic                  acc1_s;

    logic                  p0_rvalid_r;
    logic                  p0_err_r;
    logic [DATA_WIDTH-1:0] p0_rdata_r;
    logic                  p1_rvalid_r;
    logic                  p1_err_r;
    logic [DATA_WIDTH-1:0] p1_rdata_r;

    dmem_arb_fsm #(
        .MAX_HOLD (MAX_HOLD)
    ) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .p0_gnt (gnt0_s),
        .p1_gnt (gnt1_s)
    );

    assign acc0_s = p0_req & gnt0_s;
    assign acc1_s = p1_req & gnt1_s;

    // Request mux: the granted port's fields drive the memory, zeros otherwise.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_be_s    = 4'b0000;
        sel_addr_s  = {ADR_WIDTH{1'b0}};
        sel_wdata_s = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            sel_we_s    = p0_we;
            sel_be_s    = p0_be;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end else if (gnt1_s) begin
            sel_we_s    = p1_we;
            sel_be_s    = p1_be;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = 1'b0;
        end
    end

    assign err_s  = (acc0_s | acc1_s) &
                    ((sel_addr_s[BYTE_OFS_W-1:0] != {BYTE_OFS_W{1'b0}}) ||
                     (sel_addr_s[ADR_WIDTH-1:WORD_LSB] >= IDX_LIMIT));
    assign mask_s = be_to_mask(sel_be_s);

    assign mem_a  = sel_addr_s;
    assign mem_wd = (mem_rd & ~mask_s) | (sel_wdata_s & mask_s);
    // Empty byte enables and faulting requests never reach the array; reset blocks commits.
    assign mem_we = (acc0_s | acc1_s) & sel_we_s & (|sel_be_s) & ~err_s & ~rst;

    // Response registers; rdata/err only update on an acceptance for that port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid_r <= 1'b0;
            p0_err_r    <= 1'b0;
            p0_rdata_r  <= {DATA_WIDTH{1'b0}};
            p1_rvalid_r <= 1'b0;
            p1_err_r    <= 1'b0;
            p1_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            p0_rvalid_r <= acc0_s;
            p1_rvalid_r <= acc1_s;
            if (acc0_s) begin
                p0_err_r   <= err_s;
                p0_rdata_r <= err_s ? {DATA_WIDTH{1'b0}} : mem_rd;
            end
            if (acc1_s) begin
                p1_err_r   <= err_s;
                p1_rdata_r <= err_s ? {DATA_WIDTH{1'b0}} : mem_rd;
            end
        end
    end

    assign p0_gnt    = gnt0_s;
    assign p1_gnt    = gnt1_s;
    assign p0_rvalid = p0_rvalid_r;
    assign p0_err    = p0_err_r;
    assign p0_rdata  = p0_rdata_r;
    assign p1_rvalid = p1_rvalid_r;
    assign p1_err    = p1_err_r;
    assign p1_rdata  = p1_rdata_r;

endmodule
